// File: rtl/pulse_meter.sv
// Synchronizes an asynchronous level into clk and measures each high pulse width in clk cycles.
// Optional timeout feature: define PULSE_METER_TIMEOUT_EN (adds timeout/timed_out ports).
module pulse_meter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
`ifdef PULSE_METER_TIMEOUT_EN
    input  logic [15:0]      timeout,
    output logic             timed_out,
`endif
    output logic [CNT_W-1:0] width,
    output logic             overflow,
    output logic             width_valid,
    input  logic             width_ready,
    output logic [7:0]       missed,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MEASURE, REPORT, WAIT_LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int CW = (CNT_W > 16) ? CNT_W : 16;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   p;
    logic                   s;
    logic                   rise;
    logic [CNT_W-1:0]       cnt;
    logic                   ovf;
    logic                   timeout_hit;

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~p;
    assign busy = (state != IDLE);

`ifdef PULSE_METER_TIMEOUT_EN
    // Compare at a common width so narrow counters still line up with the 16-bit limit.
    assign timeout_hit = (timeout != 16'd0) && (CW'(cnt) == CW'(timeout));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            p    <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pulse_in};
            p    <= s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ovf         <= 1'b0;
            width       <= '0;
            overflow    <= 1'b0;
            width_valid <= 1'b0;
            missed      <= 8'd0;
`ifdef PULSE_METER_TIMEOUT_EN
            timed_out   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= MEASURE;
                        cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                        ovf   <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (s && timeout_hit) begin
                        width       <= cnt;
                        overflow    <= ovf;
                        width_valid <= 1'b1;
`ifdef PULSE_METER_TIMEOUT_EN
                        timed_out   <= 1'b1;
`endif
                        state       <= REPORT;
                    end else if (s) begin
                        if (cnt == CNT_MAX) ovf <= 1'b1;
                        else                cnt <= cnt + 1'b1;
                    end else begin
                        // s only drops here on a fall; a fall that coincides with the
                        // timeout count still takes this normal path.
                        width       <= cnt;
                        overflow    <= ovf;
                        width_valid <= 1'b1;
`ifdef PULSE_METER_TIMEOUT_EN
                        timed_out   <= 1'b0;
`endif
                        state       <= REPORT;
                    end
                end
                REPORT: begin
                    if (rise && missed != 8'hFF) missed <= missed + 8'd1;
                    if (width_ready) begin
                        width_valid <= 1'b0;
                        state       <= s ? WAIT_LOW : IDLE;
                    end
                end
                WAIT_LOW: begin
                    if (!s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
